timer_irq_source: RTL and testbench

//  Memory-mapped interval timer that generates the Interrupt request consumed by the CPU control unit.

---
 rtl/timer_irq_source_pkg.sv | 32 +++
 rtl/timer_irq_source_prescaler.sv | 35 +++
 rtl/timer_irq_source.sv | 148 ++++++++++++++
 tb/tb_timer_irq_source.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/timer_irq_source_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | timer_irq_source_pkg                                                       |
// | Register offsets, TCON bit indices and FSM encoding for the interval timer.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package timer_irq_source_pkg;

  localparam logic [31:0] c_off_th   = 32'd0;
  localparam logic [31:0] c_off_tl   = 32'd4;
  localparam logic [31:0] c_off_tcon = 32'd8;

  localparam int c_tcon_run = 0;
  localparam int c_tcon_ien = 1;
  localparam int c_tcon_ist = 2;

  typedef logic [1:0] state_t;
  localparam state_t c_st_stop = 2'd0;
  localparam state_t c_st_run  = 2'd1;
  localparam state_t c_st_pend = 2'd2;

  // Word-address compare; the byte offset bits of the bus address are ignored.
  function automatic logic addr_match(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] off);
    logic [31:0] w_target;
    w_target = base + off;
    return addr[31:2] == w_target[31:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_irq_source_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | timer_prescaler                                                            |
// | Enabled counter with sync clear; emits a 1-cycle tick every PRESCALE clks. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned c_cw = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(PRESCALE - 1);

  logic [c_cw-1:0] r_cnt;

  assign o_tick = i_en & (r_cnt == c_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/timer_irq_source.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | timer_irq_source                                                           |
// | Memory-mapped interval timer raising a level interrupt on TL overflow.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module timer_irq_source
  import timer_irq_source_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWr,
  input  logic        MemRd,
  output logic [31:0] ReadData,
  input  logic        kernel_mode,
  output logic        Interrupt
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  state_t      r_state;
  state_t      w_next_state;
  logic        r_irq;

  logic w_hit_th, w_hit_tl, w_hit_tcon;
  logic w_wr_th, w_wr_tl, w_wr_tcon;
  logic w_count_en, w_tick, w_ovf, w_ovf_set;

  assign w_hit_th   = addr_match(Addr, BASE_ADDR, c_off_th);
  assign w_hit_tl   = addr_match(Addr, BASE_ADDR, c_off_tl);
  assign w_hit_tcon = addr_match(Addr, BASE_ADDR, c_off_tcon);

  assign w_wr_th   = MemWr & w_hit_th;
  assign w_wr_tl   = MemWr & w_hit_tl;
  assign w_wr_tcon = MemWr & w_hit_tcon;

  // Holding the prescaler in clear while stopped restarts it from 0 on every start.
  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (reset),
    .i_en   (w_count_en),
    .i_clr  (~w_count_en),
    .o_tick (w_tick)
  );

  assign w_ovf     = w_tick & (r_tl == 32'hFFFF_FFFF);
  assign w_ovf_set = w_ovf & r_tcon[c_tcon_ien];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      if (w_wr_th) begin
        r_th <= WriteData;
      end
      if (w_wr_tl) begin
        r_tl <= WriteData;
      end else if (w_ovf) begin
        r_tl <= r_th;
      end else if (w_tick) begin
        r_tl <= r_tl + 32'd1;
      end
      if (w_wr_tcon) begin
        r_tcon <= WriteData[2:0];
      end
      // Overflow set overrides a same-cycle software clear.
      if (w_ovf_set) begin
        r_tcon[c_tcon_ist] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_stop;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_stop: begin
        if (w_wr_tcon && WriteData[c_tcon_run]) begin
          w_next_state = c_st_run;
        end
      end
      c_st_run: begin
        if (w_wr_tcon && !WriteData[c_tcon_run]) begin
          w_next_state = c_st_stop;
        end else if (w_ovf_set) begin
          w_next_state = c_st_pend;
        end
      end
      c_st_pend: begin
        if (w_wr_tcon && !WriteData[c_tcon_run]) begin
          w_next_state = c_st_stop;
        end else if (w_wr_tcon && !WriteData[c_tcon_ist] && !w_ovf_set) begin
          w_next_state = c_st_run;
        end
      end
      default: w_next_state = c_st_stop;
    endcase
  end

  always_comb begin
    w_count_en = 1'b0;
    if ((r_state == c_st_run) || (r_state == c_st_pend)) begin
      w_count_en = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_tcon[c_tcon_ist] & r_tcon[c_tcon_ien] & ~kernel_mode;
    end
  end

  assign Interrupt = r_irq;

  always_comb begin
    ReadData = 32'h0;
    if (MemRd) begin
      if (w_hit_th) begin
        ReadData = r_th;
      end else if (w_hit_tl) begin
        ReadData = r_tl;
      end else if (w_hit_tcon) begin
        ReadData = {29'd0, r_tcon};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_irq_source.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_timer_irq_source                                                        |
// | Directed bench for the interval timer at PRESCALE=1 and PRESCALE=4.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_timer_irq_source;
  import timer_irq_source_pkg::*;

  localparam logic [31:0] c_base = 32'h4000_0000;
  localparam logic [31:0] c_th   = c_base + 32'd0;
  localparam logic [31:0] c_tl   = c_base + 32'd4;
  localparam logic [31:0] c_tcon = c_base + 32'd8;
  localparam logic [31:0] c_hole = c_base + 32'd12;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr, WriteData;
  logic        MemWr, MemRd, kernel_mode;
  logic [31:0] rdata1, rdata4;
  logic        irq1, irq4;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  timer_irq_source #(.BASE_ADDR(c_base), .PRESCALE(1)) u_dut1 (
    .clk(clk), .reset(reset), .Addr(Addr), .WriteData(WriteData), .MemWr(MemWr),
    .MemRd(MemRd), .ReadData(rdata1), .kernel_mode(kernel_mode), .Interrupt(irq1)
  );

  timer_irq_source #(.BASE_ADDR(c_base), .PRESCALE(4)) u_dut4 (
    .clk(clk), .reset(reset), .Addr(Addr), .WriteData(WriteData), .MemWr(MemWr),
    .MemRd(MemRd), .ReadData(rdata4), .kernel_mode(kernel_mode), .Interrupt(irq4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Called just after a falling edge; the write lands on the following rising edge.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    Addr = a; WriteData = d; MemWr = 1'b1;
    @(negedge clk);
    MemWr = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d1, output logic [31:0] d4);
    Addr = a; MemRd = 1'b1;
    #1;
    d1 = rdata1; d4 = rdata4;
    MemRd = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d1, d4;
    reset = 1'b1; Addr = '0; WriteData = '0; MemWr = 1'b0; MemRd = 1'b0; kernel_mode = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    bus_rd(c_th, d1, d4);   check("rst_th", d1, 32'h0);
    bus_rd(c_tl, d1, d4);   check("rst_tl", d1, 32'h0);
    bus_rd(c_tcon, d1, d4); check("rst_tcon", d1, 32'h0);
    check("rst_irq1", {31'd0, irq1}, 32'd0);
    check("rst_irq4", {31'd0, irq4}, 32'd0);
    check("rst_state", {30'd0, u_dut1.r_state}, {30'd0, c_st_stop});

    // Overflow reload and interrupt latency
    bus_wr(c_th, 32'hFFFF_FFF0);
    bus_wr(c_tl, 32'hFFFF_FFFE);
    bus_wr(c_tcon, 32'h3);
    bus_rd(c_tl, d1, d4);   check("ovf_tl0", d1, 32'hFFFF_FFFE);
    @(negedge clk);
    bus_rd(c_tl, d1, d4);   check("ovf_tl1", d1, 32'hFFFF_FFFF);
    check("ovf_irq_pre", {31'd0, irq1}, 32'd0);
    @(negedge clk);
    bus_rd(c_tl, d1, d4);   check("ovf_reload", d1, 32'hFFFF_FFF0);
    bus_rd(c_tcon, d1, d4); check("ovf_tcon", d1, 32'h7);
    check("ovf_irq_same", {31'd0, irq1}, 32'd0);
    check("ovf_state", {30'd0, u_dut1.r_state}, {30'd0, c_st_pend});
    @(negedge clk);
    check("ovf_irq", {31'd0, irq1}, 32'd1);

    // Kernel-mode masking and acknowledge
    kernel_mode = 1'b1;
    @(negedge clk);
    check("kmask_irq", {31'd0, irq1}, 32'd0);
    bus_wr(c_tcon, 32'h3);
    check("ack_state", {30'd0, u_dut1.r_state}, {30'd0, c_st_run});
    bus_rd(c_tcon, d1, d4); check("ack_tcon", d1, 32'h3);
    kernel_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("ack_irq", {31'd0, irq1}, 32'd0);

    // Overflow tick coincides with a status-clearing TCON write
    bus_wr(c_tl, 32'hFFFF_FFFF);
    bus_wr(c_tcon, 32'h3);
    bus_rd(c_tcon, d1, d4); check("setwins_tcon", d1, 32'h7);
    bus_rd(c_tl, d1, d4);   check("setwins_tl", d1, 32'hFFFF_FFF0);
    check("setwins_state", {30'd0, u_dut1.r_state}, {30'd0, c_st_pend});
    check("setwins_irq0", {31'd0, irq1}, 32'd0);
    @(negedge clk);
    check("setwins_irq1", {31'd0, irq1}, 32'd1);

    // TL write coincides with an overflow tick
    bus_wr(c_tl, 32'hFFFF_FFFF);
    bus_wr(c_tl, 32'h0000_0100);
    bus_rd(c_tl, d1, d4);   check("wrwins_tl", d1, 32'h0000_0100);

    // Asynchronous reset mid-count
    bus_wr(c_tl, 32'h5);
    bus_rd(c_tl, d1, d4);   check("arst_tl_pre", d1, 32'h5);
    check("arst_irq_pre", {31'd0, irq1}, 32'd1);
    reset = 1'b1;
    #1;
    check("arst_irq", {31'd0, irq1}, 32'd0);
    bus_rd(c_tl, d1, d4);   check("arst_tl", d1, 32'h0);
    bus_rd(c_tcon, d1, d4); check("arst_tcon", d1, 32'h0);
    check("arst_state", {30'd0, u_dut1.r_state}, {30'd0, c_st_stop});
    @(negedge clk);
    reset = 1'b0;

    // Prescale of 4
    bus_wr(c_tl, 32'h0);
    bus_wr(c_tcon, 32'h1);
    repeat (3) @(negedge clk);
    bus_rd(c_tl, d1, d4);   check("ps_tl_3cyc", d4, 32'h0);
    @(negedge clk);
    bus_rd(c_tl, d1, d4);   check("ps_tl_4cyc", d4, 32'h1);
    repeat (7) @(negedge clk);
    bus_rd(c_tl, d1, d4);   check("ps_tl_11cyc", d4, 32'h2);
    @(negedge clk);
    bus_rd(c_tl, d1, d4);   check("ps_tl_12cyc", d4, 32'h3);
    bus_wr(c_tcon, 32'h0);
    repeat (8) @(negedge clk);
    bus_rd(c_tl, d1, d4);   check("ps_frozen", d4, 32'h3);
    check("ps_state", {30'd0, u_dut4.r_state}, {30'd0, c_st_stop});

    // run=0 written in a tick cycle: tick still lands, FSM stops
    bus_wr(c_tcon, 32'h1);
    bus_wr(c_tl, 32'h10);
    bus_wr(c_tcon, 32'h0);
    bus_rd(c_tl, d1, d4);   check("stop_tick_tl", d1, 32'h11);
    check("stop_tick_state", {30'd0, u_dut1.r_state}, {30'd0, c_st_stop});
    repeat (3) @(negedge clk);
    bus_rd(c_tl, d1, d4);   check("stop_frozen", d1, 32'h11);

    // Decode holes and read strobe
    bus_rd(c_hole, d1, d4); check("hole_rd1", d1, 32'h0);
    check("hole_rd4", d4, 32'h0);
    Addr = c_tl; MemRd = 1'b0;
    #1;
    check("nord_tl", rdata1, 32'h0);
    bus_rd(c_tl + 32'd1, d1, d4); check("byteoff_tl", d1, 32'h11);
    bus_wr(c_hole, 32'hFFFF_FFFF);
    bus_rd(c_th, d1, d4);   check("hole_wr_th", d1, 32'h0);
    bus_rd(c_tl, d1, d4);   check("hole_wr_tl", d1, 32'h11);
    bus_rd(c_tcon, d1, d4); check("hole_wr_tcon", d1, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
